// File: rtl/simon_pkg.sv
// simon_pkg: shared definitions for the Simon game sequencer.
//   state_t   - 4-bit state encoding, also exported on the debug port
//   colour_t  - colour codes U/L/R/D (0..3)
//   ADDR_W    - sequence memory address width
//   onehot4() - colour code to one-hot LED pattern
package simon_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GEN      = 4'd1,
    S_FETCH    = 4'd2,
    S_PLAY_ON  = 4'd3,
    S_PLAY_OFF = 4'd4,
    S_WAIT_IN  = 4'd5,
    S_CHECK    = 4'd6,
    S_FAIL     = 4'd7,
    S_WIN      = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    C_U = 2'd0,
    C_L = 2'd1,
    C_R = 2'd2,
    C_D = 2'd3
  } colour_t;

  function automatic logic [3:0] onehot4(input logic [1:0] c);
    onehot4 = 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// simon_game_ctrl_if: sequence memory bus between the game controller and
// the colour sequence RAM.
//   mem_we     - one-clk write strobe
//   mem_waddr  - write address
//   mem_wdata  - write data (colour code)
//   mem_raddr  - read address
//   mem_rdata  - read data, valid one clk after mem_raddr changes
// Modports: master = controller, slave = memory.
interface simon_game_ctrl_if;
  import simon_pkg::*;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [1:0]        mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [1:0]        mem_rdata;

  modport master (
    output mem_we, mem_waddr, mem_wdata, mem_raddr,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata, mem_raddr,
    output mem_rdata
  );

endinterface

// File: rtl/simon_tick_timer.sv
// simon_tick_timer: loadable down-counter of tick pulses.
//   clk, reset_n - clock, async active-low reset
//   load         - reload the count with load_val (wins over tick)
//   load_val     - number of ticks to count
//   tick         - timing enable pulse
//   done         - combinational: this clk carries the tick that reaches zero
module simon_tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Terminal count is flagged on the tick itself so the FSM can leave the
  // state on the same edge that consumes the last tick.
  assign done = tick && (cnt == W'(1));

endmodule

// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: Simon game sequencer. Grows a random colour sequence one
// entry per round, plays it back on the LEDs with tick-based timing and then
// checks the player's button presses against the stored sequence.
// Ports:
//   clk, reset_n      - clock, async active-low reset
//   tick              - one-clk timing enable
//   start             - request a new game (honoured in IDLE/FAIL/WIN)
//   rnd               - current LFSR value, stored as the next colour
//   btn_valid/btn_val - player press pulse and colour
//   mem               - sequence memory bus (master side)
//   led               - one-hot colour display
//   error_led         - high in FAIL
//   state             - state encoding for debug display
//   round             - current sequence length (0 in IDLE)
// Optional macro SIMON_TIMEOUT_EN: when defined, WAIT_IN falls to FAIL after
// TIMEOUT_TICKS ticks without a press; otherwise WAIT_IN waits forever.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | power-up, waiting for start
// GEN      | write rnd into memory at L-1
// FETCH    | present idx to memory, LEDs dark
// PLAY_ON  | show colour at idx for ON_TICKS ticks
// PLAY_OFF | dark gap for OFF_TICKS ticks, then next item or player turn
// WAIT_IN  | wait for the player's press for item idx
// CHECK    | compare press with stored colour
// FAIL     | wrong press (or timeout), error LED lit
// WIN      | all N items repeated, all LEDs lit
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int N             = 4,
  parameter int ON_TICKS      = 50,
  parameter int OFF_TICKS     = 25,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      tick,
  input  logic                      start,
  input  logic [1:0]                rnd,
  input  logic                      btn_valid,
  input  logic [1:0]                btn_val,
  simon_game_ctrl_if.master         mem,
  output logic [3:0]                led,
  output logic                      error_led,
  output logic [3:0]                state,
  output logic [4:0]                round
);

  localparam int TW = 16;

  state_t            st;
  logic [4:0]        len;
  logic [ADDR_W-1:0] idx;
  logic [4:0]        idx_inc;
  logic [1:0]        btn_q;

  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_done;

  assign idx_inc = {1'b0, idx} + 5'd1;
  assign state   = st;
  assign round   = len;

  // The timer reloads on every state entry: it loads in any clk that leaves
  // the current state, and the value is chosen for the state being entered.
  // Only PLAY_ON, PLAY_OFF and WAIT_IN hold the count across clks.
  always_comb begin
    tmr_load = 1'b1;
    tmr_val  = TW'(TIMEOUT_TICKS);
    case (st)
      S_FETCH:               tmr_val  = TW'(ON_TICKS);
      S_PLAY_ON: begin
        tmr_load = tmr_done;
        tmr_val  = TW'(OFF_TICKS);
      end
      S_PLAY_OFF, S_WAIT_IN: tmr_load = tmr_done;
      default: ;
    endcase
  end

  simon_tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= S_IDLE;
      len           <= '0;
      idx           <= '0;
      btn_q         <= '0;
      led           <= '0;
      error_led     <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_waddr <= '0;
      mem.mem_wdata <= '0;
      mem.mem_raddr <= '0;
    end else begin
      mem.mem_we <= 1'b0;
      case (st)
        S_IDLE, S_FAIL, S_WIN: begin
          if (start) begin
            st            <= S_GEN;
            len           <= 5'd1;
            led           <= '0;
            error_led     <= 1'b0;
            mem.mem_we    <= 1'b1;
            mem.mem_waddr <= '0;
            mem.mem_wdata <= rnd;
          end
        end
        S_GEN: begin
          idx           <= '0;
          mem.mem_raddr <= '0;
          led           <= '0;
          st            <= S_FETCH;
        end
        S_FETCH: st <= S_PLAY_ON;
        S_PLAY_ON: begin
          led <= onehot4(mem.mem_rdata);
          if (tmr_done) begin
            led <= '0;
            st  <= S_PLAY_OFF;
          end
        end
        S_PLAY_OFF: begin
          if (tmr_done) begin
            if (idx_inc == len) begin
              idx           <= '0;
              mem.mem_raddr <= '0;
              st            <= S_WAIT_IN;
            end else begin
              idx           <= idx_inc[ADDR_W-1:0];
              mem.mem_raddr <= idx_inc[ADDR_W-1:0];
              st            <= S_FETCH;
            end
          end
        end
        S_WAIT_IN: begin
          if (btn_valid) begin
            btn_q <= btn_val;
            st    <= S_CHECK;
          end
`ifdef SIMON_TIMEOUT_EN
          else if (tmr_done) begin
            error_led <= 1'b1;
            st        <= S_FAIL;
          end
`endif
        end
        S_CHECK: begin
          if (btn_q != mem.mem_rdata) begin
            error_led <= 1'b1;
            st        <= S_FAIL;
          end else if (idx_inc != len) begin
            idx           <= idx_inc[ADDR_W-1:0];
            mem.mem_raddr <= idx_inc[ADDR_W-1:0];
            st            <= S_WAIT_IN;
          end else if (len != 5'(N)) begin
            // Old L is the address of the new entry (new L - 1).
            len           <= len + 5'd1;
            mem.mem_we    <= 1'b1;
            mem.mem_waddr <= len[ADDR_W-1:0];
            mem.mem_wdata <= rnd;
            st            <= S_GEN;
          end else begin
            led <= 4'b1111;
            st  <= S_WIN;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/simon_game_ctrl.md
Name: simon_game_ctrl

Overview:
- Single-clock game sequencer for the Simon datapath.
- Grows the stored colour sequence by one LFSR value per round and writes it into the sequence memory.
- Plays the sequence back on the four LEDs with tick-based on/off timing, then checks player button pulses against memory.
- Sits between the button priority encoder, the LFSR, the sequence memory and the LED/debug outputs.

Parameters:
- N, 4: maximum sequence length; legal range 1..16.
- ON_TICKS, 50: tick pulses each LED stays lit during playback.
- OFF_TICKS, 25: tick pulses of dark gap after each playback item.
- TIMEOUT_TICKS, 500: tick pulses allowed per player input; used only with the optional feature.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  reset; asynchronous, active-low.
- tick  in  1  one-clk timing enable (~100 Hz).
- start  in  1  one-clk request to start a new game.
- rnd  in  2  current LFSR value.
- btn_valid  in  1  one-clk player-press pulse.
- btn_val  in  2  pressed colour; valid with btn_valid.
- mem_we  out  1  one-clk write strobe.
- mem_waddr  out  4  write address.
- mem_wdata  out  2  write data.
- mem_raddr  out  4  read address.
- mem_rdata  in  2  read data; synchronous, valid one clk after mem_raddr changes.
- led  out  4  one-hot colour display.
- error_led  out  1  high in FAIL.
- state  out  4  state encoding for debug display.
- round  out  5  current sequence length L (0 in IDLE).

Behaviour:
- Clocking and reset: one clk domain; all outputs registered. Asynchronous active-low reset drives:
  - state to IDLE.
  - L, idx and tick counter to 0.
  - led, error_led, mem_we, mem_waddr, mem_wdata, mem_raddr and round to 0.
- State encoding: IDLE=0, GEN=1, FETCH=2, PLAY_ON=3, PLAY_OFF=4, WAIT_IN=5, CHECK=6, FAIL=7, WIN=8.
- IDLE:
  - Outputs are 0.
  - start -> GEN with L=1.
- GEN (1 clk):
  - Asserts mem_we with mem_waddr=L-1 and mem_wdata=rnd.
  - Sets idx=0 -> FETCH.
- FETCH (1 clk):
  - mem_raddr=idx; led=0 -> PLAY_ON.
  - Guarantees rdata latency and no read-during-write.
- PLAY_ON:
  - led=1<<mem_rdata, registered on the first clk.
  - Counts tick pulses; at the ON_TICKS-th tick -> PLAY_OFF.
- PLAY_OFF:
  - led=0.
  - At the OFF_TICKS-th tick, idx++.
  - If the new idx==L -> WAIT_IN with idx=0; else -> FETCH.
- WAIT_IN:
  - led=0; mem_raddr=idx.
  - btn_valid latches btn_val -> CHECK.
- CHECK (1 clk):
  - Compares the latched value with mem_rdata.
  - Mismatch -> FAIL.
  - Match and idx<L-1 -> idx++, WAIT_IN.
  - Match and idx==L-1 and L<N -> L++, GEN.
  - Match and L==N -> WIN.
- FAIL: error_led=1, led=0; start -> GEN with L=1 and error_led cleared.
- WIN: led=4'b1111; start -> GEN with L=1.
- Ignored inputs:
  - start is ignored in every state except IDLE, FAIL and WIN.
  - btn_valid is ignored outside WAIT_IN; presses during playback are dropped, not queued.
- Timing rules:
  - Tick counter clears on every state entry.
  - A tick arriving in the entry clk counts.
  - A tick and btn_valid in the same clk are independent.
- round=L in every state except IDLE.
- With N=1, the first correct press goes straight to WIN.

Optional Feature:
- Macro: SIMON_TIMEOUT_EN.
- Defined: WAIT_IN counts ticks, and reaching TIMEOUT_TICKS without btn_valid -> FAIL. The counter restarts on each WAIT_IN entry.
- Undefined: WAIT_IN waits indefinitely; TIMEOUT_TICKS is unused.

Decomposition:
- Shared package simon_pkg holds:
  - the state encoding constants (4-bit);
  - colour codes 0..3 (U, L, R, D);
  - the memory address width (4);
  - a onehot4 function.
- One natural sub-module: simon_tick_timer.
  - Loadable tick-pulse down-counter with load, tick and done.
  - Instantiated once and shared by PLAY_ON, PLAY_OFF and the timeout.

Test Plan:
1. Reset and start: reset_n low mid-PLAY_ON -> all outputs 0 and state=0 immediately. After release, start -> one mem_we at addr 0 with wdata=rnd, then FETCH, PLAY_ON, PLAY_OFF, WAIT_IN.
2. Playback timing: ON_TICKS=3, OFF_TICKS=2, rnd=2, L=1 -> led=4'b0100 for exactly 3 ticks, then 0 for 2 ticks, then state=5.
3. Correct round: sequence {2}, btn_val=2 -> L=2 and GEN writes addr 1; playback then shows the addr 0 and addr 1 colours in order.
4. Error: sequence {1,3}, presses 1 then 0 -> CHECK then FAIL; error_led=1, round=2. start -> error_led=0, round=1.
5. Win and ignored inputs: N=2, all presses correct -> state=8, led=4'b1111. btn_valid during PLAY_ON and start during WAIT_IN produce no state change.
6. Timeout: with SIMON_TIMEOUT_EN and TIMEOUT_TICKS=5, no press -> FAIL on the 5th tick in WAIT_IN. Without the macro -> remains in WAIT_IN after 1000 ticks.
